// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch stage in front of the IF/ID pipeline register. It owns the
// fetch PC, issues reads to a synchronous instruction memory with a 1-cycle
// read latency, and buffers the returned words as {instruction, PC+4} pairs in
// a small FIFO. The FIFO head is shown to IF/ID every cycle. The ID-stage stall
// holds the head in place. A branch/jump redirect flushes the queue and
// restarts fetch at the new address.
//
// Handshake: the head is valid when instr_valid=1. It is consumed at a rising
// edge where instr_valid=1 and if_stall=0 (pop). Memory requests have no
// backpressure. imem_req=1 with imem_addr means imem_rdata carries that word
// in the following cycle.
//
// Optional feature: define IF_BUBBLE_CNT_EN to build a saturating counter of
// cycles with no valid instruction. Without it, bubble_count is tied to zero.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   reset        synchronous, active-high reset
//   imem_req     read request this cycle
//   imem_addr    read address (meaningful when imem_req=1)
//   imem_rdata   read data, valid the cycle after imem_req
//   if_stall     1 = IF/ID not accepting this cycle
//   redirect     branch/jump taken; flush and refetch
//   redirect_pc  new fetch address, sampled when redirect=1
//   instr_valid  queue head is valid
//   instr_out    head instruction; 0 (NOP) when invalid
//   pcp4_out     head PC+4; 0 when invalid
//   queue_count  occupied queue entries
//   bubble_count cycles without a valid instruction (optional feature)
// ---------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             if_stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             instr_valid,
  output logic [31:0]      instr_out,
  output logic [31:0]      pcp4_out,
  output logic [CNT_W-1:0] queue_count,
  output logic [31:0]      bubble_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic             squash_q, squash_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             pop;
  logic             push;
  logic             push_en;
  logic [CNT_W:0]   occ;
  logic             can_issue;
  entry_t           head;

  // Head outputs are purely combinational from the FIFO read pointer.
  assign head        = mem_q[rd_ptr_q];
  assign instr_valid = (count_q != '0);
  assign instr_out   = instr_valid ? head.instr : 32'h0;
  assign pcp4_out    = instr_valid ? head.pcp4  : 32'h0;
  assign queue_count = count_q;

  assign pop  = instr_valid & ~if_stall;
  // The response to last cycle's request arrives now. squash marks a response
  // whose request was cancelled by a redirect.
  assign push = inflight_q & ~squash_q;
  // Writes are suppressed when reset or redirect flushes the queue at this edge.
  assign push_en = push & ~reset & ~redirect;

  // Occupancy after this edge if a new request is issued now. The in-flight
  // word is counted as occupied, which guarantees no overflow.
  assign occ       = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign can_issue = (occ < (CNT_W+1)'(DEPTH));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    squash_d   = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    imem_req   = 1'b0;
    imem_addr  = fetch_pc_q;

    if (redirect) begin
      // Flush everything. No request this cycle. The outstanding response,
      // if any, is marked to be dropped.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      squash_d   = inflight_q;
    end else begin
      imem_req = can_issue;
      if (can_issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
        inflight_d = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Reset overrides the request decision; state is cleared in the register.
    if (reset) imem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q].instr <= imem_rdata;
      mem_q[wr_ptr_q].pcp4  <= req_pc_q + 32'd4;
    end
  end

`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] bubble_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_q <= 32'h0;
    end else if (!instr_valid && (bubble_q != 32'hFFFF_FFFF)) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bubble_count = bubble_q;
`else
  assign bubble_count = 32'h0;
`endif

endmodule
